// File: rtl/count_datapath.sv
// count_datapath: modulo-MOD counter driven by the control FSM strobes.
// Reports the current count and these status flags: zero, terminal count,
// a registered wrap pulse and a sticky overflow bit.
// Ports:
//   i_clk  - rising-edge clock
//   i_rst  - asynchronous reset, active high
//   i_ci   - count-increment strobe (level or 0->1 edge, selected by EDGE)
//   i_ld   - load strobe (loads i_din, saturated to MOD-1)
//   i_clr  - synchronous clear strobe (highest priority)
//   i_din  - load value
//   o_q    - registered count, always within 0..MOD-1
//   o_zero - o_q == 0
//   o_tc   - o_q == MOD-1
//   o_wrap - one-cycle pulse the cycle after MOD-1 -> 0
//   o_ovf  - sticky overflow: set on wrap or out-of-range load, cleared by clr
module count_datapath #(
  parameter int W    = 4,
  parameter int MOD  = 10,
  parameter int EDGE = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ci,
  input  logic         i_ld,
  input  logic         i_clr,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_q,
  output logic         o_zero,
  output logic         o_tc,
  output logic         o_wrap,
  output logic         o_ovf
);

  // Last legal count held in W+1 bits so a full-range modulus compares cleanly.
  localparam int          LAST_I = MOD - 1;
  localparam logic [W:0]  LAST   = LAST_I[W:0];

  logic [W-1:0] r_q;
  logic         r_wrap;
  logic         r_ovf;
  logic         r_ci_d;

  logic [W-1:0] w_q_nxt;
  logic         w_wrap_nxt;
  logic         w_ovf_nxt;
  logic         w_cnt_ev;
  logic         w_at_last;
  logic         w_din_oor;
  logic [W:0]   w_inc;

  assign w_cnt_ev  = (EDGE != 0) ? (i_ci & ~r_ci_d) : i_ci;
  assign w_inc     = {1'b0, r_q} + {{W{1'b0}}, 1'b1};
  assign w_at_last = ({1'b0, r_q} == LAST);
  assign w_din_oor = ({1'b0, i_din} > LAST);

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    w_ovf_nxt  = r_ovf;
    if (i_clr) begin
      w_q_nxt   = '0;
      w_ovf_nxt = 1'b0;
    end else if (i_ld) begin
      if (w_din_oor) begin
        w_q_nxt   = LAST[W-1:0];
        w_ovf_nxt = 1'b1;
      end else begin
        w_q_nxt = i_din;
      end
    end else if (w_cnt_ev) begin
      if (w_at_last) begin
        w_q_nxt    = '0;
        w_wrap_nxt = 1'b1;
        w_ovf_nxt  = 1'b1;
      end else begin
        w_q_nxt = w_inc[W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
      r_ci_d <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
      r_ovf  <= w_ovf_nxt;
      // edge detector samples ci every cycle, including clr/ld cycles
      r_ci_d <= i_ci;
    end
  end

  assign o_q    = r_q;
  assign o_zero = (r_q == '0);
  assign o_tc   = w_at_last;
  assign o_wrap = r_wrap;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_count_datapath.sv
// Bench for count_datapath: three instances (modulus 10 level, modulus 10
// edge, modulus 16 level) share one stimulus stream; a reference model
// predicts each cycle's outputs into a scoreboard queue and a monitor
// compares them.
module tb_count_datapath;

  typedef struct packed {
    logic [3:0] q;
    logic       zero;
    logic       tc;
    logic       wrap;
    logic       ovf;
  } exp_t;
  typedef exp_t [2:0] exp3_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ci  = 1'b0;
  logic       ld  = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] din = '0;

  logic [3:0] q    [3];
  logic       zero [3];
  logic       tc   [3];
  logic       wrap [3];
  logic       ovf  [3];

  always #5 clk = ~clk;

  count_datapath #(.W(4), .MOD(10), .EDGE(0)) u_lvl (
    .i_clk(clk), .i_rst(rst), .i_ci(ci), .i_ld(ld), .i_clr(clr), .i_din(din),
    .o_q(q[0]), .o_zero(zero[0]), .o_tc(tc[0]), .o_wrap(wrap[0]), .o_ovf(ovf[0]));
  count_datapath #(.W(4), .MOD(10), .EDGE(1)) u_edg (
    .i_clk(clk), .i_rst(rst), .i_ci(ci), .i_ld(ld), .i_clr(clr), .i_din(din),
    .o_q(q[1]), .o_zero(zero[1]), .o_tc(tc[1]), .o_wrap(wrap[1]), .o_ovf(ovf[1]));
  count_datapath #(.W(4), .MOD(16), .EDGE(0)) u_full (
    .i_clk(clk), .i_rst(rst), .i_ci(ci), .i_ld(ld), .i_clr(clr), .i_din(din),
    .o_q(q[2]), .o_zero(zero[2]), .o_tc(tc[2]), .o_wrap(wrap[2]), .o_ovf(ovf[2]));

  // reference model state
  int    mq[3], movf[3], mwrap[3], mcid[3];
  int    errors = 0;
  int    checks = 0;
  string tname  = "reset";
  exp3_t sb[$];

  function automatic int mod_of(int k);
    return (k == 2) ? 16 : 10;
  endfunction

  function automatic exp_t mk(int k);
    exp_t e;
    e.q    = 4'(mq[k]);
    e.zero = (mq[k] == 0);
    e.tc   = (mq[k] == mod_of(k) - 1);
    e.wrap = (mwrap[k] != 0);
    e.ovf  = (movf[k] != 0);
    return e;
  endfunction

  function automatic exp_t act(int k);
    exp_t a;
    a.q = q[k]; a.zero = zero[k]; a.tc = tc[k]; a.wrap = wrap[k]; a.ovf = ovf[k];
    return a;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = 0; movf[k] = 0; mwrap[k] = 0; mcid[k] = 0;
    end
  endtask

  task automatic model_step(bit c, bit l, bit cl, int d);
    bit ev;
    for (int k = 0; k < 3; k++) begin
      ev = (k == 1) ? (c && mcid[k] == 0) : c;
      mwrap[k] = 0;
      if (cl) begin
        mq[k] = 0; movf[k] = 0;
      end else if (l) begin
        if (d < mod_of(k)) mq[k] = d;
        else begin mq[k] = mod_of(k) - 1; movf[k] = 1; end
      end else if (ev) begin
        if (mq[k] == mod_of(k) - 1) begin mwrap[k] = 1; movf[k] = 1; end
        mq[k] = (mq[k] + 1) % mod_of(k);
      end
      mcid[k] = c;
    end
  endtask

  task automatic chk(string nm, int k, exp_t a, exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s inst%0d: got q=%0d z=%b tc=%b wrap=%b ovf=%b, want q=%0d z=%b tc=%b wrap=%b ovf=%b",
               nm, k, a.q, a.zero, a.tc, a.wrap, a.ovf, e.q, e.zero, e.tc, e.wrap, e.ovf);
    end
  endtask

  // one stimulus cycle: drive at negedge, predict, push expectation
  task automatic cyc(bit c, bit l, bit cl, int d);
    exp3_t e;
    @(negedge clk);
    ci = c; ld = l; clr = cl; din = 4'(d);
    model_step(c, l, cl, d);
    for (int k = 0; k < 3; k++) e[k] = mk(k);
    sb.push_back(e);
  endtask

  // monitor: every clock, compare DUT outputs with the oldest prediction
  initial begin
    exp3_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) chk(tname, k, act(k), e[k]);
      end
    end
  end

  initial begin
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) chk("reset", k, act(k), mk(k));
    @(negedge clk);
    rst = 1'b0;

    // asynchronous reset mid-count, checked before any clock edge
    tname = "count_to_7";
    repeat (7) cyc(1, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    for (int k = 0; k < 3; k++) chk("async_rst", k, act(k), mk(k));
    @(negedge clk);
    ci = 1'b0; ld = 1'b0; clr = 1'b0;
    rst = 1'b0;

    tname = "count_wrap";
    cyc(0, 0, 1, 0);
    repeat (12) cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);

    tname = "load";
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 6);
    cyc(0, 1, 0, 12);
    cyc(0, 0, 0, 0);

    tname = "priority";
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 5);
    cyc(1, 1, 1, 0);
    cyc(0, 1, 0, 5);
    cyc(1, 1, 0, 3);
    cyc(0, 1, 0, 9);
    cyc(1, 0, 1, 0);   // clear beats a pending wrap

    tname = "edge";
    cyc(0, 0, 1, 0);
    repeat (3) begin
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    cyc(1, 1, 0, 2);
    cyc(1, 0, 0, 0);   // ci still high after ld: no edge
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);

    tname = "clr_after_ovf";
    cyc(0, 1, 0, 15);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    tname = "random";
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)));
    end
    cyc(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
